// File: rtl/spi_master.sv
// SPI master: one start pulse runs one framed transfer of 8*NBYTES bits, MSB first,
// with runtime CPOL/CPHA and an mclk derived from clk by a fixed divider of DIV cycles.
module spi_master #(
  parameter int NBYTES = 1,
  parameter int DIV    = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cpol_i,
  input  logic                  cpha_i,
  input  logic                  start_i,
  input  logic [8*NBYTES-1:0]   din_i,
  output logic [8*NBYTES-1:0]   dout_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  select_o,
  output logic                  mclk_o,
  output logic                  mosi_o,
  input  logic                  miso_i
);

  localparam int W  = 8 * NBYTES;
  localparam int EW = $clog2(2 * W + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [EW-1:0] EDGES    = EW'(2 * W);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_TRAIL = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t          state_q;
  logic [DW-1:0]   div_q;
  logic [EW-1:0]   edges_q;
  logic [W-1:0]    sh_q;
  logic [W-1:0]    dout_q;
  logic            cpha_q;
  logic            select_q;
  logic            busy_q;
  logic            done_q;
  logic            mclk_q;
  logic            mosi_q;

  logic            tick;
  logic            is_sample;

  // Edges remaining counts down from 2W, so an even remaining count marks a leading edge.
  always_comb begin
    tick      = (div_q == DIV_LAST);
    is_sample = (~edges_q[0]) ^ cpha_q;
  end

  // Frame sequencer, divider, shift register and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      edges_q  <= '0;
      sh_q     <= '0;
      dout_q   <= '0;
      cpha_q   <= 1'b0;
      select_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mclk_q   <= cpol_i;
      mosi_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      div_q  <= (state_q == S_IDLE || tick) ? '0 : div_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          mclk_q <= cpol_i;
          if (start_i) begin
            sh_q     <= din_i;
            cpha_q   <= cpha_i;
            select_q <= 1'b1;
            busy_q   <= 1'b1;
            mosi_q   <= din_i[W-1];
            edges_q  <= EDGES;
            state_q  <= S_LEAD;
          end
        end
        // The first mclk edge lands on the tick that ends the lead-in.
        S_LEAD, S_SHIFT: begin
          if (tick) begin
            mclk_q  <= ~mclk_q;
            edges_q <= edges_q - 1'b1;
            if (is_sample) begin
              sh_q <= {sh_q[W-2:0], miso_i};
            end else begin
              mosi_q <= sh_q[W-1];
            end
            state_q <= (edges_q == EW'(1)) ? S_TRAIL : S_SHIFT;
          end
        end
        S_TRAIL: begin
          if (tick) begin
            select_q <= 1'b0;
            state_q  <= S_GAP;
          end
        end
        S_GAP: begin
          if (tick) begin
            dout_q  <= sh_q;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dout_o   = dout_q;
  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign select_o = select_q;
  assign mclk_o   = mclk_q;
  assign mosi_o   = mosi_q;

endmodule
